// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared constants for the pong core: updater states, sequencer phases, winner codes
package pong_pkg;

  localparam logic [1:0] UPD_RESET     = 2'd0;
  localparam logic [1:0] UPD_PLAY_NEXT = 2'd1;
  localparam logic [1:0] UPD_PLAY      = 2'd2;

  typedef enum logic [2:0] {
    PH_IDLE       = 3'd0,
    PH_ARM        = 3'd1,
    PH_SERVE_WAIT = 3'd2,
    PH_RALLY      = 3'd3,
    PH_GAME_OVER  = 3'd4
  } phase_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_BOTH = 2'b11;

endpackage

// File: rtl/press_debouncer.sv
// rtl/press_debouncer.sv - frame-rate hold counter producing a one-frame press per button hold
module press_debouncer #(
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic vsync,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam logic [3:0] LIMIT = 4'(DEBOUNCE_FRAMES);

  logic [3:0] hold_cnt;
  logic       release_seen;
  logic       low_seen;
  logic       fire;

  // low_seen stays clear after reset until the button is observed low, so a
  // button held across reset deassertion never counts.
  assign fire = btn && release_seen && low_seen && (hold_cnt == LIMIT - 4'd1);

  always_ff @(posedge vsync or negedge rst) begin
    if (!rst) begin
      hold_cnt     <= 4'd0;
      release_seen <= 1'b1;
      low_seen     <= 1'b0;
      press        <= 1'b0;
    end else begin
      press <= fire;
      if (!btn) begin
        hold_cnt     <= 4'd0;
        release_seen <= 1'b1;
        low_seen     <= 1'b1;
      end else begin
        if (hold_cnt != LIMIT) hold_cnt <= hold_cnt + 4'd1;
        if (fire) release_seen <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pong_match_sequencer.sv
// rtl/pong_match_sequencer.sv - match-level phase FSM driving the game_state_updater rst/start
module pong_match_sequencer
  import pong_pkg::*;
#(
  parameter int WIN_SCORE       = 7,
  parameter int SERVE_FRAMES    = 120,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic       vsync,
  input  logic       rst,
  input  logic       z1,
  input  logic       c1,
  input  logic       z2,
  input  logic       c2,
  input  logic [7:0] player1_score,
  input  logic [7:0] player2_score,
  input  logic [1:0] upd_state,
  output logic       upd_rst,
  output logic       upd_start,
  output logic [2:0] phase,
  output logic [7:0] countdown,
  output logic [1:0] winner
);

  localparam logic [7:0] CD_LOAD = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] WIN_LIM = 8'(WIN_SCORE);

  phase_t     state, state_nxt;
  logic [7:0] cd_nxt;
  logic [1:0] win_nxt;
  logic       start_nxt;
  logic       press;
  logic       p1_at_lim, p2_at_lim;

  press_debouncer #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_press_debouncer (
    .vsync(vsync),
    .rst  (rst),
    .btn  (z1 | c1 | z2 | c2),
    .press(press)
  );

  assign p1_at_lim = (player1_score >= WIN_LIM);
  assign p2_at_lim = (player2_score >= WIN_LIM);
  assign phase     = state;

  always_ff @(posedge vsync or negedge rst) begin
    if (!rst) begin
      state     <= PH_IDLE;
      upd_rst   <= 1'b1;
      upd_start <= 1'b0;
      countdown <= 8'd0;
      winner    <= WIN_NONE;
    end else begin
      state     <= state_nxt;
      upd_rst   <= (state_nxt == PH_IDLE);
      upd_start <= start_nxt;
      countdown <= cd_nxt;
      winner    <= win_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cd_nxt    = 8'd0;
    win_nxt   = winner;
    start_nxt = 1'b0;
    case (state)
      PH_IDLE: begin
        if (press) begin
          state_nxt = PH_ARM;
          start_nxt = 1'b1;
        end
      end
      PH_ARM: begin
        state_nxt = PH_SERVE_WAIT;
        cd_nxt    = CD_LOAD;
      end
      PH_SERVE_WAIT: begin
        if (countdown != 8'd0) begin
          cd_nxt = countdown - 8'd1;
        end else if (upd_state == UPD_PLAY_NEXT) begin
          state_nxt = PH_RALLY;
          start_nxt = 1'b1;
        end
      end
      PH_RALLY: begin
        // During the serve-pulse frame the updater still reads PLAY_NEXT;
        // that is not a point, so decisions wait until the pulse is gone.
        if (!upd_start) begin
          if (upd_state == UPD_PLAY_NEXT) begin
            if (p1_at_lim || p2_at_lim) begin
              state_nxt = PH_GAME_OVER;
              win_nxt   = {p2_at_lim, p1_at_lim};
            end else begin
              state_nxt = PH_SERVE_WAIT;
              cd_nxt    = CD_LOAD;
            end
          end else if (upd_state == UPD_RESET) begin
            state_nxt = PH_IDLE;
          end
        end
      end
      PH_GAME_OVER: begin
        if (press) begin
          state_nxt = PH_IDLE;
          win_nxt   = WIN_NONE;
        end
      end
      default: state_nxt = PH_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pong_match_sequencer.sv
// tb/tb_pong_match_sequencer.sv - directed self-checking bench for pong_match_sequencer
module tb_pong_match_sequencer;

  logic       vsync = 1'b0;
  logic       rst;
  logic       z1, c1, z2, c2;
  logic [7:0] player1_score, player2_score;
  logic [1:0] upd_state;
  logic       upd_rst, upd_start;
  logic [2:0] phase;
  logic [7:0] countdown;
  logic [1:0] winner;

  int n_cmp  = 0;
  int n_fail = 0;

  pong_match_sequencer #(
    .WIN_SCORE(7), .SERVE_FRAMES(120), .DEBOUNCE_FRAMES(3)
  ) dut (
    .vsync(vsync), .rst(rst),
    .z1(z1), .c1(c1), .z2(z2), .c2(c2),
    .player1_score(player1_score), .player2_score(player2_score),
    .upd_state(upd_state),
    .upd_rst(upd_rst), .upd_start(upd_start),
    .phase(phase), .countdown(countdown), .winner(winner)
  );

  always #5 vsync = ~vsync;

  task automatic tick();
    @(posedge vsync);
    #1;
  endtask

  // Waits out a full serve countdown from SERVE_WAIT entry and leaves the DUT in RALLY with the updater in PLAY.
  task automatic serve_to_rally();
    upd_state = 2'd1;
    repeat (120) tick();
    upd_state = 2'd2;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; z1 = 0; c1 = 0; z2 = 0; c2 = 0;
    player1_score = 0; player2_score = 0; upd_state = 2'd0;
    #23;
    n_cmp++; if (phase !== 3'd0)     begin n_fail++; $display("FAIL reset_phase: got %0d want 0", phase); end
    n_cmp++; if (upd_rst !== 1'b1)   begin n_fail++; $display("FAIL reset_upd_rst: got %0b want 1", upd_rst); end
    n_cmp++; if (upd_start !== 1'b0) begin n_fail++; $display("FAIL reset_upd_start: got %0b want 0", upd_start); end
    n_cmp++; if (countdown !== 8'd0) begin n_fail++; $display("FAIL reset_countdown: got %0d want 0", countdown); end
    n_cmp++; if (winner !== 2'b00)   begin n_fail++; $display("FAIL reset_winner: got %b want 00", winner); end
    tick();
    rst = 1'b1;
    tick(); tick();
    n_cmp++; if (phase !== 3'd0 || upd_rst !== 1'b1) begin n_fail++; $display("FAIL idle_after_reset: phase %0d upd_rst %0b want 0/1", phase, upd_rst); end
  endtask

  task automatic test_first_serve();
    z1 = 1'b1;
    tick(); tick(); tick();
    n_cmp++; if (phase !== 3'd0) begin n_fail++; $display("FAIL press_latency_early: phase %0d want 0", phase); end
    tick();
    n_cmp++; if (phase !== 3'd1 || upd_start !== 1'b1 || upd_rst !== 1'b0) begin
      n_fail++; $display("FAIL arm: phase %0d start %0b rst %0b want 1/1/0", phase, upd_start, upd_rst); end
    z1 = 1'b0;
    upd_state = 2'd1;
    tick();
    n_cmp++; if (phase !== 3'd2 || countdown !== 8'd119 || upd_start !== 1'b0) begin
      n_fail++; $display("FAIL serve_wait_entry: phase %0d cd %0d start %0b want 2/119/0", phase, countdown, upd_start); end
    for (int k = 118; k >= 0; k--) begin
      logic [7:0] exp_cd;
      exp_cd = 8'(k);
      tick();
      n_cmp++; if (countdown !== exp_cd || upd_start !== 1'b0 || phase !== 3'd2) begin
        n_fail++; $display("FAIL countdown_run: cd %0d start %0b phase %0d want %0d/0/2", countdown, upd_start, phase, exp_cd); end
    end
    tick();
    n_cmp++; if (phase !== 3'd3 || upd_start !== 1'b1 || countdown !== 8'd0) begin
      n_fail++; $display("FAIL serve_pulse: phase %0d start %0b cd %0d want 3/1/0", phase, upd_start, countdown); end
    upd_state = 2'd2;
    tick();
    n_cmp++; if (phase !== 3'd3 || upd_start !== 1'b0) begin
      n_fail++; $display("FAIL serve_pulse_single: phase %0d start %0b want 3/0", phase, upd_start); end
  endtask

  task automatic test_point_no_win();
    player2_score = 8'd1;
    upd_state = 2'd1;
    tick();
    n_cmp++; if (phase !== 3'd2 || countdown !== 8'd119 || winner !== 2'b00 || upd_start !== 1'b0) begin
      n_fail++; $display("FAIL point_no_win: phase %0d cd %0d win %b start %0b want 2/119/00/0", phase, countdown, winner, upd_start); end
    serve_to_rally();
    n_cmp++; if (phase !== 3'd3) begin n_fail++; $display("FAIL rally_again: phase %0d want 3", phase); end
  endtask

  task automatic test_match_win();
    player1_score = 8'd7;
    upd_state = 2'd1;
    tick();
    n_cmp++; if (phase !== 3'd4 || winner !== 2'b01 || upd_start !== 1'b0) begin
      n_fail++; $display("FAIL match_win: phase %0d win %b start %0b want 4/01/0", phase, winner, upd_start); end
    tick();
    n_cmp++; if (phase !== 3'd4 || upd_start !== 1'b0 || winner !== 2'b01) begin
      n_fail++; $display("FAIL game_over_hold: phase %0d start %0b win %b want 4/0/01", phase, upd_start, winner); end
    z2 = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      logic [2:0] exp_ph;
      exp_ph = (i < 4) ? 3'd4 : 3'd0;
      tick();
      n_cmp++; if (phase !== exp_ph || upd_start !== 1'b0) begin
        n_fail++; $display("FAIL rematch_hold frame %0d: phase %0d start %0b want %0d/0", i, phase, upd_start, exp_ph); end
      if (i == 4) begin
        n_cmp++; if (upd_rst !== 1'b1 || winner !== 2'b00) begin
          n_fail++; $display("FAIL rematch_idle: rst %0b win %b want 1/00", upd_rst, winner); end
      end
    end
    z2 = 1'b0;
    player1_score = 0; player2_score = 0; upd_state = 2'd0;
    tick();
  endtask

  task automatic test_debounce();
    c2 = 1'b1;
    tick(); tick();
    c2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (phase !== 3'd0) begin n_fail++; $display("FAIL glitch_no_press: phase %0d want 0", phase); end
    end
    c2 = 1'b1;
    tick(); tick(); tick();
    n_cmp++; if (phase !== 3'd0) begin n_fail++; $display("FAIL debounce_early: phase %0d want 0", phase); end
    tick();
    n_cmp++; if (phase !== 3'd1 || upd_start !== 1'b1) begin
      n_fail++; $display("FAIL debounce_press: phase %0d start %0b want 1/1", phase, upd_start); end
  endtask

  task automatic test_stall_desync();
    upd_state = 2'd2;
    tick();
    n_cmp++; if (phase !== 3'd2 || countdown !== 8'd119) begin
      n_fail++; $display("FAIL stall_entry: phase %0d cd %0d want 2/119", phase, countdown); end
    repeat (5) tick();
    c2 = 1'b0;
    repeat (114) tick();
    n_cmp++; if (countdown !== 8'd0) begin n_fail++; $display("FAIL stall_zero: cd %0d want 0", countdown); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (phase !== 3'd2 || countdown !== 8'd0 || upd_start !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold: phase %0d cd %0d start %0b want 2/0/0", phase, countdown, upd_start); end
    end
    upd_state = 2'd1;
    tick();
    n_cmp++; if (phase !== 3'd3 || upd_start !== 1'b1) begin
      n_fail++; $display("FAIL stall_release: phase %0d start %0b want 3/1", phase, upd_start); end
    upd_state = 2'd2;
    tick();
    upd_state = 2'd0;
    tick();
    n_cmp++; if (phase !== 3'd0 || upd_rst !== 1'b1 || upd_start !== 1'b0) begin
      n_fail++; $display("FAIL desync_idle: phase %0d rst %0b start %0b want 0/1/0", phase, upd_rst, upd_start); end
  endtask

  task automatic test_reset_mid_rally();
    z1 = 1'b1;
    repeat (4) tick();
    z1 = 1'b0;
    upd_state = 2'd1;
    tick();
    serve_to_rally();
    n_cmp++; if (phase !== 3'd3) begin n_fail++; $display("FAIL pre_reset_rally: phase %0d want 3", phase); end
    z1 = 1'b1;
    #3 rst = 1'b0;
    #1;
    n_cmp++; if (phase !== 3'd0 || upd_rst !== 1'b1 || upd_start !== 1'b0 || countdown !== 8'd0 || winner !== 2'b00) begin
      n_fail++; $display("FAIL async_reset: phase %0d rst %0b start %0b cd %0d win %b want 0/1/0/0/00",
                         phase, upd_rst, upd_start, countdown, winner); end
    tick(); tick();
    rst = 1'b1;
    upd_state = 2'd0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++; if (phase !== 3'd0 || upd_start !== 1'b0) begin
        n_fail++; $display("FAIL held_through_reset: phase %0d start %0b want 0/0", phase, upd_start); end
    end
    z1 = 1'b0;
    tick();
    z1 = 1'b1;
    tick(); tick(); tick();
    n_cmp++; if (phase !== 3'd0) begin n_fail++; $display("FAIL repress_early: phase %0d want 0", phase); end
    tick();
    n_cmp++; if (phase !== 3'd1 || upd_start !== 1'b1) begin
      n_fail++; $display("FAIL repress_arm: phase %0d start %0b want 1/1", phase, upd_start); end
    z1 = 1'b0;
  endtask

  task automatic test_both_win();
    upd_state = 2'd1;
    tick();
    serve_to_rally();
    player1_score = 8'd9;
    player2_score = 8'd7;
    upd_state = 2'd1;
    tick();
    n_cmp++; if (phase !== 3'd4 || winner !== 2'b11) begin
      n_fail++; $display("FAIL both_win: phase %0d win %b want 4/11", phase, winner); end
  endtask

  initial begin
    test_reset();
    test_first_serve();
    test_point_no_win();
    test_match_win();
    test_debounce();
    test_stall_desync();
    test_reset_mid_rally();
    test_both_win();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
